alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester arbiter and sequencer that time-shares one 32-bit ALU instance between independent clients, for example the main datapath and an address/branch unit. Each client presents an operation with a valid/ready handshake. The block grants the ALU round-robin, registers the operands, waits one cycle for the ALU to settle, and returns the registered result and zero flag to the granted client as a one-cycle response pulse. Operation codes the ALU does not support are flagged instead of silently returning zero.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; must equal the ALU width
- OP_WIDTH, 4, ALU operation code width

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low; one clock, no other clock domains
- req0_valid  input  1  client 0 has an operation pending
- req0_ready  output  1  client 0 operation accepted this cycle
- req0_op  input  OP_WIDTH  client 0 ALU operation code
- req0_a, req0_b  input  DATA_WIDTH  client 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as client 0, for client 1
- alu_op  output  OP_WIDTH  operation code driven to the shared ALU
- alu_a, alu_b  output  DATA_WIDTH  operands driven to the shared ALU
- alu_result  input  DATA_WIDTH  combinational ALU result
- alu_zero  input  1  combinational ALU zero flag
- rsp0_valid, rsp1_valid  output  1  one-cycle response strobe, per client
- rsp_result  output  DATA_WIDTH  registered result, shared by both clients
- rsp_zero  output  1  registered zero flag
- rsp_err  output  1  the completed operation used an unsupported code

## Operation
- Supported codes: AND=0000, OR=0001, NOR=0010, ADD=0011, SUB=0100. Every other code is unsupported.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Arbitrate among the asserted reqN_valid.
  - The winner gets reqN_ready=1 combinationally in that same cycle. Only IDLE ever asserts ready.
  - On acceptance: capture op/a/b into the operand registers, record the owner ID, update last_grant, and go to EXEC.
  - If no client is valid, stay in IDLE.
- EXEC: the operand registers drive alu_op/a/b. At the end of the cycle, capture alu_result and alu_zero, compute err from the captured op, then go to RESP.
- RESP:
  - Assert rsp{owner}_valid=1 for exactly one cycle, with rsp_result/rsp_zero/rsp_err stable.
  - Go to IDLE unconditionally. There is no response backpressure.
- Arbitration:
  - If only one client is valid, it wins.
  - If both are valid, the client that is not last_grant wins.
  - last_grant resets to 1, so client 0 wins the first contention.
- Unsupported code:
  - The operation executes normally on the ALU.
  - rsp_err=1, rsp_result carries alu_result unchanged, rsp_zero is forced to 0.
- Handshake:
  - A client holds valid, op, a and b stable until it sees ready.
  - A client may drop valid before ready; nothing is captured.
  - A client may reassert valid in its own RESP cycle. That request is considered in the next IDLE cycle.
- alu_op/a/b hold the last captured operands in all states; they are not driven from client inputs directly.
- rsp_result/rsp_zero/rsp_err hold their value until the next EXEC capture.

## Timing
- Latency: acceptance at edge T (valid&ready high in cycle T) puts the response in cycle T+2. rsp_valid is high only between edges T+2 and T+3.
- Throughput: one operation per 3 cycles, even when back-to-back requests are pending.
- Reset (async, asserted low), every output immediately:
  - state=IDLE, last_grant=1
  - alu_op=0000, alu_a=alu_b=0
  - rsp_result=0, rsp_zero=0, rsp_err=0
  - req*_ready=0, rsp*_valid=0
- Reset during EXEC or RESP aborts the operation: no response strobe after release.
- Reset release: the first acceptance can occur in the first cycle after reset deasserts.
- Simultaneous events:
  - Both valid in IDLE: exactly one ready is asserted, never both.
  - A request arriving during EXEC/RESP waits with ready=0.

## Test plan
- Single client 0: ADD a=5, b=7 held valid → req0_ready in cycle 0; alu_a=5, alu_b=7 in cycle 1; rsp0_valid cycle 2 with result=12, zero=0, err=0; rsp1_valid stays 0.
- Zero flag: client 1 SUB a=0x1234, b=0x1234 → rsp1_valid at T+2 with result=0, zero=1.
- Contention after reset: both valid continuously (c0 OR 0xF0|0x0F, c1 NOR 0|0) → grant order c0, c1, c0, c1; responses 0xFF, then 0xFFFFFFFF, each 3 cycles apart.
- Unsupported code: op=0111 → rsp_err=1, rsp_zero=0, rsp_result=0; next valid AND op → rsp_err=0.
- Reset mid-operation: assert reset in EXEC → all outputs zero immediately, no rsp strobe after release; with both clients valid after release, client 0 granted first.
- Withdrawn request: client 1 raises valid for one cycle while busy, then drops it → no req1_ready, no rsp1_valid, operand registers unchanged.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one external combinational ALU between two clients. Each
// accepted operation takes three cycles: accept (IDLE), ALU settle and
// result capture (EXEC), then a one-cycle response strobe (RESP).
// Arbitration is round-robin; opcodes the ALU does not implement are
// still executed but flagged through rsp_err.

module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,

  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,

  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  // state | meaning
  // ------+---------------------------------------------------------------
  // IDLE  | arbitrate; the winner sees ready and its operands are captured
  // EXEC  | captured operands drive the ALU; result/zero/err sampled at end
  // RESP  | rsp{owner}_valid pulses for this single cycle; always to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Codes 0..4 (AND, OR, NOR, ADD, SUB) are the ones the ALU implements.
  localparam logic [OP_WIDTH-1:0] OP_LAST_SUPPORTED = OP_WIDTH'(4);

  state_t                state;
  logic                  last_grant;
  logic                  owner;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  err_q;
  logic                  rsp0_q;
  logic                  rsp1_q;

  logic                  grant0;
  logic                  grant1;
  logic                  op_unsupported;
  logic [OP_WIDTH-1:0]   win_op;
  logic [DATA_WIDTH-1:0] win_a;
  logic [DATA_WIDTH-1:0] win_b;

  // Round-robin grant: a lone requester always wins; under contention the
  // client that did not win last time is served.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
  end

  // Operand mux for the winning client; only meaningful when a grant is up.
  always_comb begin
    win_op = req0_op;
    win_a  = req0_a;
    win_b  = req0_b;
    if (grant1) begin
      win_op = req1_op;
      win_a  = req1_a;
      win_b  = req1_b;
    end
  end

  assign op_unsupported = (op_q > OP_LAST_SUPPORTED);

  // Ready is combinational from IDLE, and held low while reset is asserted
  // so a client never sees a handshake the flops are not going to take.
  assign req0_ready = grant0 && reset;
  assign req1_ready = grant1 && reset;

  // Sequencer: operand capture, result capture and response strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
    end else begin
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_q       <= win_op;
            a_q        <= win_a;
            b_q        <= win_b;
            owner      <= grant1;
            last_grant <= grant1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Unsupported codes pass the ALU result through untouched but
          // never report zero, so a client cannot mistake them for a match.
          result_q <= alu_result;
          zero_q   <= alu_zero && !op_unsupported;
          err_q    <= op_unsupported;
          rsp0_q   <= !owner;
          rsp1_q   <= owner;
          state    <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_NOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] req0_op, req1_op, alu_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [DW-1:0] alu_a, alu_b, alu_result, rsp_result;
  logic          alu_zero, rsp0_valid, rsp1_valid, rsp_zero, rsp_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Behavioural model of the shared ALU; unsupported codes yield 0.
  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOR:  return ~(a | b);
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  // Assert reset for two edges, release just after an edge: the caller is
  // then in the first cycle after release.
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive0(1'b1, OP_ADD, 32'd1, 32'd2);
    drive1(1'b1, OP_SUB, 32'd3, 32'd4);
    reset = 1'b0;
    #3;
    vectors++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
    vectors++;
    if ({alu_op, alu_a, alu_b, rsp_result, rsp_zero, rsp_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got op=%h a=%h b=%h res=%h z=%b e=%b expected all zero",
               alu_op, alu_a, alu_b, rsp_result, rsp_zero, rsp_err);
    end
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    drive1(1'b0, 4'd0, 32'd0, 32'd0);
    do_reset();
  endtask

  task automatic test_single();
    next_cycle();
    drive0(1'b1, OP_ADD, 32'd5, 32'd7);
    mid_cycle();
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    next_cycle();
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    mid_cycle();
    vectors++;
    if ({alu_op, alu_a, alu_b} !== {OP_ADD, 32'd5, 32'd7}) begin
      miscompares++;
      $display("FAIL single_operands: got %h/%h/%h expected 3/5/7", alu_op, alu_a, alu_b);
    end
    vectors++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_early_rsp: got %b expected 00", {rsp0_valid, rsp1_valid});
    end
    next_cycle();
    mid_cycle();
    vectors++;
    if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_rsp_valid: got %b expected 10", {rsp0_valid, rsp1_valid});
    end
    vectors++;
    if ({rsp_result, rsp_zero, rsp_err} !== {32'd12, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_rsp_data: got %h z=%b e=%b expected 0000000c z=0 e=0", rsp_result, rsp_zero, rsp_err);
    end
    next_cycle();
    mid_cycle();
    vectors++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_rsp_pulse: got %b expected 00", {rsp0_valid, rsp1_valid});
    end
  endtask

  task automatic test_zero();
    next_cycle();
    drive1(1'b1, OP_SUB, 32'h1234, 32'h1234);
    mid_cycle();
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL zero_ready: got %b expected 01", {req0_ready, req1_ready});
    end
    next_cycle();
    drive1(1'b0, 4'd0, 32'd0, 32'd0);
    next_cycle();
    mid_cycle();
    vectors++;
    if ({rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err} !== {2'b01, 32'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL zero_rsp: got v=%b res=%h z=%b e=%b expected v=01 res=0 z=1 e=0",
               {rsp0_valid, rsp1_valid}, rsp_result, rsp_zero, rsp_err);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy, exp_rsp;
    logic [31:0] exp_res;
    do_reset();
    drive0(1'b1, OP_OR, 32'hF0, 32'h0F);
    drive1(1'b1, OP_NOR, 32'h0, 32'h0);
    for (int k = 0; k < 12; k++) begin
      mid_cycle();
      exp_rdy = {(k % 6) == 0, (k % 6) == 3};
      exp_rsp = {(k % 6) == 2, (k % 6) == 5};
      exp_res = ((k % 6) == 2) ? 32'hFF : 32'hFFFF_FFFF;
      vectors++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== {exp_rdy, exp_rsp}) begin
        miscompares++;
        $display("FAIL contention_cycle%0d: got rdy=%b rsp=%b expected rdy=%b rsp=%b",
                 k, {req0_ready, req1_ready}, {rsp0_valid, rsp1_valid}, exp_rdy, exp_rsp);
      end
      if (exp_rsp != 2'b00) begin
        vectors++;
        if ({rsp_result, rsp_err} !== {exp_res, 1'b0}) begin
          miscompares++;
          $display("FAIL contention_result%0d: got %h e=%b expected %h e=0", k, rsp_result, rsp_err, exp_res);
        end
      end
      next_cycle();
    end
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    drive1(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic test_unsupported();
    next_cycle();
    drive0(1'b1, 4'b0111, 32'h55, 32'hAA);
    mid_cycle();
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL unsup_ready: got %b expected 1", req0_ready);
    end
    next_cycle();
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    mid_cycle();
    vectors++;
    if (alu_op !== 4'b0111) begin
      miscompares++;
      $display("FAIL unsup_alu_op: got %h expected 7", alu_op);
    end
    next_cycle();
    mid_cycle();
    vectors++;
    if ({rsp0_valid, rsp_result, rsp_zero, rsp_err} !== {1'b1, 32'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL unsup_rsp: got v=%b res=%h z=%b e=%b expected v=1 res=0 z=0 e=1",
               rsp0_valid, rsp_result, rsp_zero, rsp_err);
    end
    next_cycle();
    drive0(1'b1, OP_AND, 32'hF0, 32'h0F);
    next_cycle();
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    next_cycle();
    mid_cycle();
    vectors++;
    if ({rsp0_valid, rsp_result, rsp_zero, rsp_err} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL unsup_followup: got v=%b res=%h z=%b e=%b expected v=1 res=0 z=1 e=0",
               rsp0_valid, rsp_result, rsp_zero, rsp_err);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    drive0(1'b1, OP_ADD, 32'd1, 32'd2);
    mid_cycle();
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_ready: got %b expected 1", req0_ready);
    end
    next_cycle();
    drive1(1'b1, OP_SUB, 32'd9, 32'd4);
    reset = 1'b0;
    #1;
    vectors++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_err, alu_op, alu_a, alu_b, rsp_result} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got rdy=%b rsp=%b op=%h a=%h b=%h res=%h expected all zero",
               {req0_ready, req1_ready}, {rsp0_valid, rsp1_valid}, alu_op, alu_a, alu_b, rsp_result);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    mid_cycle();
    vectors++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b1000) begin
      miscompares++;
      $display("FAIL rstmid_first_grant: got rdy=%b rsp=%b expected rdy=10 rsp=00",
               {req0_ready, req1_ready}, {rsp0_valid, rsp1_valid});
    end
    next_cycle();
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    drive1(1'b0, 4'd0, 32'd0, 32'd0);
    mid_cycle();
    vectors++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_no_stale_rsp: got %b expected 00", {rsp0_valid, rsp1_valid});
    end
    next_cycle();
    mid_cycle();
    vectors++;
    if ({rsp0_valid, rsp1_valid, rsp_result} !== {2'b10, 32'd3}) begin
      miscompares++;
      $display("FAIL rstmid_rsp: got v=%b res=%h expected v=10 res=3", {rsp0_valid, rsp1_valid}, rsp_result);
    end
  endtask

  task automatic test_withdraw();
    next_cycle();
    drive0(1'b1, OP_ADD, 32'd10, 32'd20);
    next_cycle();
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    drive1(1'b1, OP_SUB, 32'd99, 32'd1);
    mid_cycle();
    vectors++;
    if (req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_busy_ready: got %b expected 0", req1_ready);
    end
    next_cycle();
    drive1(1'b0, 4'd0, 32'd0, 32'd0);
    mid_cycle();
    vectors++;
    if ({rsp0_valid, rsp1_valid, rsp_result} !== {2'b10, 32'd30}) begin
      miscompares++;
      $display("FAIL withdraw_rsp: got v=%b res=%h expected v=10 res=1e", {rsp0_valid, rsp1_valid}, rsp_result);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mid_cycle();
      vectors++;
      if ({req1_ready, rsp0_valid, rsp1_valid, alu_op, alu_a, alu_b} !== {3'b000, OP_ADD, 32'd10, 32'd20}) begin
        miscompares++;
        $display("FAIL withdraw_idle%0d: got rdy1=%b rsp=%b op=%h a=%h b=%h expected 0/00/3/a/14",
                 k, req1_ready, {rsp0_valid, rsp1_valid}, alu_op, alu_a, alu_b);
      end
    end
  endtask

  // Transaction-level model: an accepted op frees the block three cycles
  // later and answers two cycles later; contention alternates winners.
  task automatic test_random(input int ncyc);
    logic        v [2];
    logic [3:0]  op [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic        took [2];
    logic        last, idle, e_r0, e_r1, w;
    int          free_at, due;
    logic        owner;
    logic [3:0]  cap_op;
    logic [31:0] cap_a, cap_b, exp_res, hold_res;
    logic        exp_zero, exp_err, hold_zero, hold_err;
    do_reset();
    last = 1'b1; free_at = 0; due = -10; owner = 1'b0;
    cap_op = '0; cap_a = '0; cap_b = '0;
    exp_res = '0; exp_zero = 1'b0; exp_err = 1'b0;
    hold_res = '0; hold_zero = 1'b0; hold_err = 1'b0;
    for (int c = 0; c < 2; c++) begin
      v[c] = 1'b0; op[c] = '0; a[c] = '0; b[c] = '0; took[c] = 1'b1;
    end
    for (int k = 0; k < ncyc; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (took[c] || !v[c]) begin
          v[c]  = ($urandom_range(0, 2) != 0);
          op[c] = 4'($urandom_range(0, 7));
          a[c]  = $urandom;
          b[c]  = ($urandom_range(0, 3) == 0) ? a[c] : $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
          v[c] = 1'b0;
        end
        took[c] = 1'b0;
      end
      drive0(v[0], op[0], a[0], b[0]);
      drive1(v[1], op[1], a[1], b[1]);
      mid_cycle();
      idle = (k >= free_at);
      e_r0 = idle && v[0] && (!v[1] || last);
      e_r1 = idle && v[1] && (!v[0] || !last);
      vectors++;
      if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin
        miscompares++;
        $display("FAIL rand_ready_c%0d: got %b expected %b", k, {req0_ready, req1_ready}, {e_r0, e_r1});
      end
      if (k == due - 1) begin
        vectors++;
        if ({alu_op, alu_a, alu_b} !== {cap_op, cap_a, cap_b}) begin
          miscompares++;
          $display("FAIL rand_alu_c%0d: got %h/%h/%h expected %h/%h/%h", k, alu_op, alu_a, alu_b, cap_op, cap_a, cap_b);
        end
      end
      if (k == due) begin
        hold_res = exp_res; hold_zero = exp_zero; hold_err = exp_err;
      end
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== {(k == due) && !owner, (k == due) && owner}) begin
        miscompares++;
        $display("FAIL rand_rsp_valid_c%0d: got %b expected %b", k, {rsp0_valid, rsp1_valid},
                 {(k == due) && !owner, (k == due) && owner});
      end
      vectors++;
      if ({rsp_result, rsp_zero, rsp_err} !== {hold_res, hold_zero, hold_err}) begin
        miscompares++;
        $display("FAIL rand_rsp_data_c%0d: got %h z=%b e=%b expected %h z=%b e=%b",
                 k, rsp_result, rsp_zero, rsp_err, hold_res, hold_zero, hold_err);
      end
      if (e_r0 || e_r1) begin
        w        = e_r1;
        owner    = w;
        cap_op   = op[w]; cap_a = a[w]; cap_b = b[w];
        exp_res  = alu_f(cap_op, cap_a, cap_b);
        exp_err  = (cap_op > OP_SUB);
        exp_zero = (exp_res == 32'd0) && !exp_err;
        due      = k + 2;
        free_at  = k + 3;
        last     = w;
        took[w]  = 1'b1;
      end
      next_cycle();
    end
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    drive1(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    drive1(1'b0, 4'd0, 32'd0, 32'd0);
    test_reset();
    test_single();
    test_zero();
    test_contention();
    test_unsupported();
    test_reset_mid();
    test_withdraw();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
